// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL reset/lock bring-up with bounded retries, lock-loss recovery
// and glitch-safe dynamic phase stepping gated by a settle window.
module pll_lock_sequencer #(
  parameter int RST_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 27000,
  parameter int STABLE_CYCLES = 2700,
  parameter int SETTLE_CYCLES = 64,
  parameter int MAX_RETRY = 3,
  parameter logic [3:0] PSDA_DEFAULT = 4'b0100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [3:0] pll_psda,
  input  logic       phase_req,
  input  logic [3:0] phase_val,
  output logic       phase_ack,
  output logic       sys_resetn,
  output logic       locked,
  output logic       fault,
  output logic [1:0] retry_count
);
  localparam int M1 = RST_CYCLES > TIMEOUT_CYCLES ? RST_CYCLES : TIMEOUT_CYCLES;
  localparam int M2 = M1 > STABLE_CYCLES ? M1 : STABLE_CYCLES;
  localparam int MAXC = M2 > SETTLE_CYCLES ? M2 : SETTLE_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {RST_PLL, WAIT_LOCK, STABLE, RUN, SETTLE, FAULT} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0] retry_nxt;
  logic [3:0] psda_nxt;
  logic armed, armed_nxt, ack_nxt, lock_meta, lock;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      lock_meta <= 1'b0;
      lock <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock <= lock_meta;
    end
  always_comb begin
    nxt = state;
    cnt_nxt = cnt + CW'(1);
    retry_nxt = retry_count;
    psda_nxt = pll_psda;
    armed_nxt = armed | ~phase_req;
    ack_nxt = 1'b0;
    case (state)
      RST_PLL:
        if (cnt == CW'(RST_CYCLES - 1)) begin
          nxt = WAIT_LOCK;
          cnt_nxt = '0;
        end
      WAIT_LOCK:
        if (lock) begin
          nxt = STABLE;
          cnt_nxt = '0;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          retry_nxt = retry_count + 2'd1;
          nxt = (retry_nxt == 2'(MAX_RETRY)) ? FAULT : RST_PLL;
          cnt_nxt = '0;
        end
      STABLE:
        if (!lock) begin
          nxt = WAIT_LOCK;
          cnt_nxt = '0;
        end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
          nxt = RUN;
          cnt_nxt = '0;
          retry_nxt = 2'd0;
        end
      RUN: begin
        cnt_nxt = '0;
        if (!lock) nxt = RST_PLL;
        else if (phase_req && armed) begin
          nxt = SETTLE;
          psda_nxt = phase_val;
          armed_nxt = 1'b0;
        end
      end
      SETTLE:
        if (!lock) begin
          nxt = RST_PLL;
          cnt_nxt = '0;
        end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          nxt = RUN;
          cnt_nxt = '0;
          ack_nxt = 1'b1;
        end
      FAULT: cnt_nxt = '0;
      default: begin
        nxt = RST_PLL;
        cnt_nxt = '0;
      end
    endcase
  end
  // Outputs are registered from the next state so they are glitch-free and track state exactly.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= RST_PLL;
      cnt <= '0;
      retry_count <= 2'd0;
      pll_psda <= PSDA_DEFAULT;
      armed <= 1'b0;
      phase_ack <= 1'b0;
      pll_reset <= 1'b1;
      sys_resetn <= 1'b0;
      locked <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      retry_count <= retry_nxt;
      pll_psda <= psda_nxt;
      armed <= armed_nxt;
      phase_ack <= ack_nxt;
      pll_reset <= (nxt == RST_PLL) || (nxt == FAULT);
      sys_resetn <= (nxt == RUN) || (nxt == SETTLE);
      locked <= (nxt == RUN);
      fault <= (nxt == FAULT);
    end
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed bring-up, retry, glitch, phase-step and reset checks.
module tb_pll_lock_sequencer;
  logic clk = 1'b0, resetn = 1'b0, pll_lock = 1'b0, phase_req = 1'b0;
  logic [3:0] phase_val = 4'h0;
  logic pll_reset, phase_ack, sys_resetn, locked, fault;
  logic [3:0] pll_psda;
  logic [1:0] retry_count;
  int n_cmp = 0, n_err = 0;
  int n, acks, sys_seen;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .RST_CYCLES(4), .TIMEOUT_CYCLES(100), .STABLE_CYCLES(20),
    .SETTLE_CYCLES(8), .MAX_RETRY(3), .PSDA_DEFAULT(4'b0100)
  ) dut (
    .clk(clk), .resetn(resetn), .pll_lock(pll_lock), .pll_reset(pll_reset),
    .pll_psda(pll_psda), .phase_req(phase_req), .phase_val(phase_val),
    .phase_ack(phase_ack), .sys_resetn(sys_resetn), .locked(locked),
    .fault(fault), .retry_count(retry_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".pll_reset"}, pll_reset, 1);
    chk({tag, ".sys_resetn"}, sys_resetn, 0);
    chk({tag, ".locked"}, locked, 0);
    chk({tag, ".fault"}, fault, 0);
    chk({tag, ".ack"}, phase_ack, 0);
    chk({tag, ".retry"}, retry_count, 0);
    chk({tag, ".psda"}, pll_psda, 4'b0100);
  endtask

  initial begin
    pll_lock = 1'b1;
    repeat (3) tick;
    chk_reset_vals("por");
    // normal bring-up
    resetn = 1'b1;
    n = 0;
    while (pll_reset && n < 50) begin n++; tick; end
    chk("rst_len", n, 4);
    n = 0;
    while (!locked && n < 200) begin n++; tick; end
    chk("lock_time", n, 21);
    chk("run.sys_resetn", sys_resetn, 1);
    chk("run.retry", retry_count, 0);
    chk("run.pll_reset", pll_reset, 0);
    chk("run.fault", fault, 0);
    // phase step with held request
    phase_val = 4'hA;
    phase_req = 1'b1;
    tick;
    chk("ph.psda", pll_psda, 4'hA);
    chk("ph.locked", locked, 0);
    chk("ph.sys_resetn", sys_resetn, 1);
    n = 0;
    acks = 0;
    while (!locked && n < 50) begin n++; acks += phase_ack; tick; end
    chk("ph.settle_len", n, 8);
    chk("ph.early_ack", acks, 0);
    chk("ph.ack", phase_ack, 1);
    acks = 0;
    repeat (20) begin tick; acks += phase_ack; end
    chk("ph.held_acks", acks, 0);
    chk("ph.held_locked", locked, 1);
    chk("ph.held_psda", pll_psda, 4'hA);
    phase_req = 1'b0;
    tick;
    phase_val = 4'h3;
    phase_req = 1'b1;
    tick;
    chk("ph2.psda", pll_psda, 4'h3);
    n = 0;
    while (!phase_ack && n < 50) begin n++; tick; end
    chk("ph2.ack_delay", n, 8);
    phase_req = 1'b0;
    // lock loss in RUN
    pll_lock = 1'b0;
    n = 0;
    while (sys_resetn && n < 10) begin n++; tick; end
    chk("loss.delay", n, 3);
    chk("loss.locked", locked, 0);
    chk("loss.pll_reset", pll_reset, 1);
    chk("loss.psda", pll_psda, 4'h3);
    pll_lock = 1'b1;
    n = 0;
    while (pll_reset && n < 50) begin n++; tick; end
    chk("loss.rst_len", n, 4);
    n = 0;
    while (!locked && n < 200) begin n++; tick; end
    chk("loss.relock", locked, 1);
    chk("loss.psda_kept", pll_psda, 4'h3);
    chk("loss.retry", retry_count, 0);
    // reset while in SETTLE
    phase_val = 4'h5;
    phase_req = 1'b1;
    tick;
    chk("rs.psda", pll_psda, 4'h5);
    chk("rs.locked", locked, 0);
    tick;
    tick;
    resetn = 1'b0;
    #1;
    chk_reset_vals("rst_settle");
    acks = 0;
    repeat (3) begin tick; acks += phase_ack; end
    chk("rs.acks", acks, 0);
    phase_req = 1'b0;
    // one-cycle lock glitch at STABLE count 10
    resetn = 1'b1;
    n = 0;
    while (pll_reset && n < 50) begin n++; tick; end
    chk("gl.rst_len", n, 4);
    repeat (11) tick;
    pll_lock = 1'b0;
    tick;
    pll_lock = 1'b1;
    n = 0;
    while (!locked && n < 200) begin tick; n++; end
    chk("gl.relock_delay", n, 23);
    chk("gl.retry", retry_count, 0);
    // lock stuck low: three timeouts then fault
    resetn = 1'b0;
    pll_lock = 1'b0;
    tick;
    tick;
    resetn = 1'b1;
    sys_seen = 0;
    n = 0;
    while (retry_count != 2'd1 && n < 300) begin tick; n++; sys_seen += sys_resetn; end
    chk("to.retry1", n, 104);
    n = 0;
    while (retry_count != 2'd2 && n < 300) begin tick; n++; sys_seen += sys_resetn; end
    chk("to.retry2", n, 104);
    n = 0;
    while (!fault && n < 300) begin tick; n++; sys_seen += sys_resetn; end
    chk("to.fault_delay", n, 104);
    chk("to.retry3", retry_count, 3);
    chk("to.pll_reset", pll_reset, 1);
    chk("to.locked", locked, 0);
    chk("to.sys_seen", sys_seen, 0);
    pll_lock = 1'b1;
    repeat (50) tick;
    chk("flt.fault", fault, 1);
    chk("flt.pll_reset", pll_reset, 1);
    chk("flt.sys_resetn", sys_resetn, 0);
    chk("flt.retry", retry_count, 3);
    // reset clears fault
    resetn = 1'b0;
    #1;
    chk_reset_vals("rst_fault");
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
